// File: rtl/sp_sram_coef_ctrl.sv
// Single-port coefficient SRAM controller: host pass-through in UPDATE mode,
// in-order coefficient streaming to the MAC on every accepted input sample.
module sp_sram_coef_ctrl #(
  parameter int SRAM_DEPTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  iClk,
  input  logic                  iRsn,
  input  logic                  iCoeffUpdateFlag,
  input  logic                  iCsnRam,
  input  logic                  iWrnRam,
  input  logic [ADDR_WIDTH-1:0] iAddrRam,
  input  logic [DATA_WIDTH-1:0] iWrDtRam,
  output logic [DATA_WIDTH-1:0] oRdDtRam,
  input  logic                  iEnSample,
  output logic                  oCsn,
  output logic                  oWrn,
  output logic [ADDR_WIDTH-1:0] oAddr,
  output logic [DATA_WIDTH-1:0] oWrDt,
  input  logic [DATA_WIDTH-1:0] iRdDt,
  output logic [DATA_WIDTH-1:0] oCoeff,
  output logic                  oCoeffValid,
  output logic [ADDR_WIDTH-1:0] oCoeffIdx,
  output logic                  oLast,
  output logic                  oBusy,
  output logic                  oSampleDrop
);

  // Handshake: there is no back-pressure. oCoeffValid qualifies oCoeff/oCoeffIdx
  // for exactly one cycle each; the MAC must accept every valid beat.

  typedef enum logic [1:0] {IDLE, UPDATE, READ, DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST    = ADDR_WIDTH'(SRAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_M1 = ADDR_WIDTH'(SRAM_DEPTH - 2);

  state_t                state;
  logic                  fetch_act;  // SRAM read of a fetch is in flight this cycle
  logic                  rd_vld;     // SRAM is returning a fetch word next cycle
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  start_fetch;
  logic                  host_oob;

  assign start_fetch = (state == IDLE) && !iCoeffUpdateFlag && iEnSample;
  assign host_oob    = 32'(iAddrRam) >= 32'(SRAM_DEPTH);

  assign oCoeff   = iRdDt;
  assign oRdDtRam = iRdDt;

  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      state       <= IDLE;
      oCsn        <= 1'b1;
      oWrn        <= 1'b1;
      oAddr       <= '0;
      oWrDt       <= '0;
      fetch_act   <= 1'b0;
      rd_vld      <= 1'b0;
      rd_idx      <= '0;
      oCoeffValid <= 1'b0;
      oCoeffIdx   <= '0;
      oLast       <= 1'b0;
      oBusy       <= 1'b0;
      oSampleDrop <= 1'b0;
    end else begin
      // Index tracks the address one stage behind the SRAM's output register.
      rd_vld      <= fetch_act;
      rd_idx      <= oAddr;
      oCoeffValid <= rd_vld;
      oCoeffIdx   <= rd_idx;
      oLast       <= rd_vld && (rd_idx == LAST);
      oBusy       <= start_fetch || fetch_act || rd_vld;
      oSampleDrop <= 1'b0;

      case (state)
        IDLE: begin
          oCsn <= 1'b1;
          oWrn <= 1'b1;
          if (iCoeffUpdateFlag) begin
            state       <= UPDATE;
            oSampleDrop <= iEnSample;
          end else if (iEnSample) begin
            state     <= READ;
            oCsn      <= 1'b0;
            oAddr     <= '0;
            fetch_act <= 1'b1;
          end
        end
        UPDATE: begin
          oSampleDrop <= iEnSample;
          if (!iCoeffUpdateFlag) begin
            state <= IDLE;
            oCsn  <= 1'b1;
            oWrn  <= 1'b1;
          end else begin
            oCsn  <= iCsnRam | host_oob;
            oWrn  <= iWrnRam;
            oAddr <= iAddrRam;
            oWrDt <= iWrDtRam;
          end
        end
        READ: begin
          oSampleDrop <= iEnSample;
          oAddr       <= oAddr + ADDR_WIDTH'(1);
          if (oAddr == LAST_M1) state <= DRAIN;
        end
        DRAIN: begin
          oSampleDrop <= iEnSample;
          oCsn        <= 1'b1;
          fetch_act   <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sp_sram_coef_ctrl.sv
// Bench for sp_sram_coef_ctrl: behavioural SRAM, timeline-based reference model
// with a per-cycle compare, directed scenarios followed by randomized traffic.
module tb_sp_sram_coef_ctrl;

  localparam int D  = 10;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NC = 20000;

  logic          iClk, iRsn, iCoeffUpdateFlag, iCsnRam, iWrnRam, iEnSample;
  logic [AW-1:0] iAddrRam;
  logic [DW-1:0] iWrDtRam, oRdDtRam, oWrDt, iRdDt, oCoeff;
  logic          oCsn, oWrn, oCoeffValid, oLast, oBusy, oSampleDrop;
  logic [AW-1:0] oAddr, oCoeffIdx;

  sp_sram_coef_ctrl #(.SRAM_DEPTH(D), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .iClk(iClk), .iRsn(iRsn), .iCoeffUpdateFlag(iCoeffUpdateFlag),
    .iCsnRam(iCsnRam), .iWrnRam(iWrnRam), .iAddrRam(iAddrRam), .iWrDtRam(iWrDtRam),
    .oRdDtRam(oRdDtRam), .iEnSample(iEnSample), .oCsn(oCsn), .oWrn(oWrn),
    .oAddr(oAddr), .oWrDt(oWrDt), .iRdDt(iRdDt), .oCoeff(oCoeff),
    .oCoeffValid(oCoeffValid), .oCoeffIdx(oCoeffIdx), .oLast(oLast),
    .oBusy(oBusy), .oSampleDrop(oSampleDrop)
  );

  // ---------------- clock / reset ----------------
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // ---------------- SRAM: address registered, then output register ----------------
  logic [DW-1:0] sram [0:15];
  logic [DW-1:0] sram_rd;
  initial begin
    for (int i = 0; i < 16; i++) sram[i] = '0;
    sram_rd = '0;
    iRdDt   = '0;
  end
  always @(posedge iClk) begin
    if (oCsn === 1'b0) begin
      if (oWrn === 1'b0) sram[oAddr] <= oWrDt;
      else               sram_rd     <= sram[oAddr];
    end
    iRdDt <= sram_rd;
  end

  // ---------------- reference model: expected-output timeline ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  bit            started = 0;
  int            m_mode = 0;  // 0 idle, 1 host update, 2 fetch (incl. drain)
  int            m_k = 0;
  int            m_e = 0;
  logic          m_csn = 1'b1, m_wrn = 1'b1, m_rst = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wrdt = '0;
  logic [DW-1:0] m_mem [0:D-1];
  bit            exp_valid [0:NC-1];
  int            exp_idx   [0:NC-1];
  logic [DW-1:0] exp_coeff [0:NC-1];
  bit            exp_busy  [0:NC-1];
  bit            exp_drop  [0:NC-1];
  bit            exp_rdv   [0:NC-1];
  logic [DW-1:0] exp_rd    [0:NC-1];

  initial for (int i = 0; i < D; i++) m_mem[i] = '0;

  always @(posedge iClk) begin
    cyc = cyc + 1;
    m_e = cyc;
    if (iRsn === 1'b0) begin
      started = 1;
      m_mode = 0;
      m_csn = 1'b1; m_wrn = 1'b1; m_addr = '0; m_wrdt = '0; m_rst = 1'b1;
      for (int j = 0; j < 16; j++) begin
        exp_valid[m_e+j] = 0; exp_busy[m_e+j] = 0; exp_drop[m_e+j] = 0; exp_rdv[m_e+j] = 0;
      end
    end else begin
      m_rst = 1'b0;
      exp_drop[m_e] = 0;
      case (m_mode)
        0: begin
          m_csn = 1'b1; m_wrn = 1'b1;
          if (iCoeffUpdateFlag) begin
            m_mode = 1;
            exp_drop[m_e] = iEnSample;
          end else if (iEnSample) begin
            m_mode = 2; m_k = m_e; m_csn = 1'b0; m_addr = '0;
            for (int i = 0; i < D; i++) begin
              exp_valid[m_e+2+i] = 1; exp_idx[m_e+2+i] = i; exp_coeff[m_e+2+i] = m_mem[i];
            end
            for (int j = 0; j <= D + 1; j++) exp_busy[m_e+j] = 1;
          end
        end
        1: begin
          exp_drop[m_e] = iEnSample;
          if (!iCoeffUpdateFlag) begin
            m_mode = 0; m_csn = 1'b1; m_wrn = 1'b1;
          end else begin
            m_csn  = iCsnRam | (int'(iAddrRam) >= D);
            m_wrn  = iWrnRam;
            m_addr = iAddrRam;
            m_wrdt = iWrDtRam;
            if (!m_csn && !m_wrn) m_mem[iAddrRam] = iWrDtRam;
            if (!m_csn && m_wrn) begin
              exp_rdv[m_e+2] = 1; exp_rd[m_e+2] = m_mem[iAddrRam];
            end
          end
        end
        default: begin
          exp_drop[m_e] = iEnSample;
          if (m_e - m_k == D) begin
            m_mode = 0; m_csn = 1'b1;
          end else begin
            m_addr = AW'(m_e - m_k);
          end
        end
      endcase
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge iClk) begin
    if (started) begin
      chk("csn", 32'(oCsn), 32'(m_csn));
      chk("wrn", 32'(oWrn), 32'(m_wrn));
      if (!m_csn || m_rst) chk("addr", 32'(oAddr), 32'(m_addr));
      if ((!m_csn && !m_wrn) || m_rst) chk("wrdt", 32'(oWrDt), 32'(m_wrdt));
      chk("valid", 32'(oCoeffValid), 32'(exp_valid[cyc]));
      if (exp_valid[cyc]) begin
        chk("idx", 32'(oCoeffIdx), 32'(exp_idx[cyc]));
        chk("coeff", 32'(oCoeff), 32'(exp_coeff[cyc]));
      end else if (m_rst) begin
        chk("idx_rst", 32'(oCoeffIdx), 32'd0);
      end
      chk("last", 32'(oLast), (exp_valid[cyc] && exp_idx[cyc] == D - 1) ? 32'd1 : 32'd0);
      chk("busy", 32'(oBusy), 32'(exp_busy[cyc]));
      chk("drop", 32'(oSampleDrop), 32'(exp_drop[cyc]));
      if (exp_rdv[cyc]) chk("rddt", 32'(oRdDtRam), 32'(exp_rd[cyc]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge iClk);
  endtask

  task automatic noise_tick(input int n);
    repeat (n) begin
      @(negedge iClk);
      iCsnRam  = 1'($urandom_range(0, 1));
      iWrnRam  = 1'($urandom_range(0, 1));
      iAddrRam = AW'($urandom_range(0, 15));
      iWrDtRam = DW'($urandom);
    end
  endtask

  task automatic pulse_en();
    @(negedge iClk); iEnSample = 1'b1;
    @(negedge iClk); iEnSample = 1'b0;
  endtask

  task automatic host_write(input int a, input int d);
    @(negedge iClk);
    iCsnRam = 1'b0; iWrnRam = 1'b0; iAddrRam = AW'(a); iWrDtRam = DW'(d);
  endtask

  task automatic host_idle();
    iCsnRam = 1'b1; iWrnRam = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    iRsn = 1'b0; iCoeffUpdateFlag = 1'b0; iEnSample = 1'b0;
    iCsnRam = 1'b1; iWrnRam = 1'b1; iAddrRam = '0; iWrDtRam = '0;
    tick(3);
    iRsn = 1'b1;

    // Idle after reset
    tick(5);
    chk("idle_csn", 32'(oCsn), 32'd1);
    chk("idle_busy", 32'(oBusy), 32'd0);

    // Host update: load coefficients, out-of-range write, read-back
    iCoeffUpdateFlag = 1'b1;
    tick(2);
    for (int i = 0; i < D; i++) host_write(i, 'h11 * (i + 1));
    host_write(12, 'hBEEF);
    @(negedge iClk);
    chk("oob_csn", 32'(oCsn), 32'd1);
    iCsnRam = 1'b0; iWrnRam = 1'b1; iAddrRam = AW'(3);
    @(negedge iClk); host_idle();
    tick(2);
    chk("readback3", 32'(oRdDtRam), 32'h0044);
    iCoeffUpdateFlag = 1'b0;
    tick(3);

    // Single fetch with literal sequence
    pulse_en();
    @(negedge iClk);
    chk("pre_valid", 32'(oCoeffValid), 32'd0);
    for (int i = 0; i < D; i++) begin
      @(negedge iClk);
      chk("lit_coeff", 32'(oCoeff), 32'('h11 * (i + 1)));
      chk("lit_idx", 32'(oCoeffIdx), 32'(i));
      chk("lit_last", 32'(oLast), (i == D - 1) ? 32'd1 : 32'd0);
    end
    @(negedge iClk);
    chk("busy_fall", 32'(oBusy), 32'd0);
    tick(4);

    // Early second pulse dropped, pulse at +12 accepted
    pulse_en();
    tick(3);
    pulse_en();
    tick(6);
    pulse_en();
    tick(20);

    // Update flag raised mid-fetch, then simultaneous flag + sample in idle
    pulse_en();
    tick(4);
    iCoeffUpdateFlag = 1'b1;
    tick(14);
    chk("upd_after_fetch_csn", 32'(oCsn), 32'd1);
    iCoeffUpdateFlag = 1'b0;
    tick(3);
    @(negedge iClk); iCoeffUpdateFlag = 1'b1; iEnSample = 1'b1;
    @(negedge iClk); iEnSample = 1'b0;
    chk("both_drop", 32'(oSampleDrop), 32'd1);
    tick(3);
    iCoeffUpdateFlag = 1'b0;
    tick(3);

    // Reset mid-fetch
    pulse_en();
    tick(5);
    iRsn = 1'b0;
    @(negedge iClk);
    iRsn = 1'b1;
    chk("rst_valid", 32'(oCoeffValid), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    tick(15);

    // Randomized traffic
    for (int it = 0; it < 300 && cyc < NC - 300; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          pulse_en();
          noise_tick($urandom_range(0, 16));
        end
        4, 5: begin
          iCoeffUpdateFlag = 1'b1;
          noise_tick($urandom_range(2, 12));
          iCoeffUpdateFlag = 1'b0;
          host_idle();
          tick(2);
        end
        6: begin
          pulse_en();
          noise_tick($urandom_range(0, 12));
          iCoeffUpdateFlag = 1'b1;
          noise_tick(15);
          iCoeffUpdateFlag = 1'b0;
          tick(2);
        end
        7: begin
          @(negedge iClk); iCoeffUpdateFlag = 1'b1; iEnSample = 1'b1;
          @(negedge iClk); iEnSample = 1'b0;
          noise_tick($urandom_range(1, 5));
          iCoeffUpdateFlag = 1'b0;
          tick(2);
        end
        8: begin
          pulse_en();
          noise_tick($urandom_range(0, 12));
          iRsn = 1'b0;
          @(negedge iClk);
          iRsn = 1'b1;
        end
        default: begin
          repeat (6) begin
            @(negedge iClk);
            iEnSample = 1'($urandom_range(0, 1));
          end
          @(negedge iClk); iEnSample = 1'b0;
          tick(12);
        end
      endcase
    end
    tick(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
